// File: rtl/stream_wb_burst_writer_if.sv
`default_nettype none
// ============================================================================
// stream_wb_burst_writer_if : stream sink + Wishbone B4 write-master bundle
// Revision 1.0
// ============================================================================
interface stream_wb_burst_writer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [DW-1:0]   stream_s_data_i;
    logic            stream_s_valid_i;
    logic            stream_s_ready_o;

    logic [AW-1:0]   wbm_adr_o;
    logic [DW-1:0]   wbm_dat_o;
    logic [DW/8-1:0] wbm_sel_o;
    logic            wbm_we_o;
    logic            wbm_cyc_o;
    logic            wbm_stb_o;
    logic [2:0]      wbm_cti_o;
    logic [1:0]      wbm_bte_o;
    logic            wbm_ack_i;
    logic            wbm_err_i;

    modport master (
        input  stream_s_data_i,
        input  stream_s_valid_i,
        output stream_s_ready_o,
        output wbm_adr_o,
        output wbm_dat_o,
        output wbm_sel_o,
        output wbm_we_o,
        output wbm_cyc_o,
        output wbm_stb_o,
        output wbm_cti_o,
        output wbm_bte_o,
        input  wbm_ack_i,
        input  wbm_err_i
    );

    modport slave (
        output stream_s_data_i,
        output stream_s_valid_i,
        input  stream_s_ready_o,
        input  wbm_adr_o,
        input  wbm_dat_o,
        input  wbm_sel_o,
        input  wbm_we_o,
        input  wbm_cyc_o,
        input  wbm_stb_o,
        input  wbm_cti_o,
        input  wbm_bte_o,
        output wbm_ack_i,
        output wbm_err_i
    );
endinterface
`default_nettype wire

// File: rtl/stream_wb_burst_writer.sv
`default_nettype none
// ============================================================================
// stream_wb_burst_writer : valid/ready word stream -> Wishbone B4 linear bursts
// Revision 1.0
// ============================================================================
module stream_wb_burst_writer #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int BURST_LEN = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_start_i,
    input  logic [AW-1:0] cfg_adr_i,
    input  logic [AW-1:0] cfg_len_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    stream_wb_burst_writer_if.master bus
);
    localparam int                  c_BEAT_W   = $clog2(BURST_LEN) + 1;
    localparam logic [AW-1:0]       c_STEP     = AW'(DW / 8);
    localparam logic [AW-1:0]       c_BURST_AW = AW'(BURST_LEN);
    localparam logic [c_BEAT_W-1:0] c_BURST_BW = c_BEAT_W'(BURST_LEN);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_GAP    = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic                  r_hold_valid;
    logic [DW-1:0]         r_hold_data;
    logic [AW-1:0]         r_addr;
    logic [AW-1:0]         r_words_left;
    logic [AW-1:0]         r_words_in;
    logic [c_BEAT_W-1:0]   r_beat;
    logic [c_BEAT_W-1:0]   r_burst;
    logic                  r_cyc;
    logic                  r_err;
    logic                  r_done;

    logic                  w_stb;
    logic                  w_ack;
    logic                  w_err;
    logic                  w_last;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_load;
    logic                  w_rearm;
    logic                  w_done_set;
    logic                  w_err_set;
    logic                  w_err_clr;

    function automatic logic [c_BEAT_W-1:0] f_burst(input logic [AW-1:0] n);
        f_burst = (n > c_BURST_AW) ? c_BURST_BW : n[c_BEAT_W-1:0];
    endfunction

    assign w_stb    = (r_state == S_ACTIVE) && r_hold_valid;
    // An error on the same beat as an ack wins; the beat is not counted.
    assign w_err    = w_stb && bus.wbm_err_i;
    assign w_ack    = w_stb && bus.wbm_ack_i && !bus.wbm_err_i;
    assign w_last   = (r_beat == (r_burst - c_BEAT_W'(1)));
    assign w_ready  = (r_state == S_ACTIVE) && (r_words_in != '0) &&
                      (!r_hold_valid || (w_stb && bus.wbm_ack_i));
    assign w_accept = w_ready && bus.stream_s_valid_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_rearm      = 1'b0;
        w_done_set   = 1'b0;
        w_err_set    = 1'b0;
        w_err_clr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cfg_start_i) begin
                    w_err_clr = 1'b1;
                    if (cfg_len_i != '0) begin
                        w_load       = 1'b1;
                        w_state_next = S_ACTIVE;
                    end else begin
                        w_done_set = 1'b1;
                    end
                end
            end
            S_ACTIVE: begin
                if (w_err) begin
                    w_err_set    = 1'b1;
                    w_done_set   = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_ack && w_last) begin
                    w_state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (r_words_left == '0) begin
                    w_done_set   = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_rearm      = 1'b1;
                    w_state_next = S_ACTIVE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
            r_addr       <= '0;
            r_words_left <= '0;
            r_words_in   <= '0;
            r_beat       <= '0;
            r_burst      <= '0;
            r_cyc        <= 1'b0;
            r_err        <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= w_done_set;
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_err_clr) begin
                r_err <= 1'b0;
            end

            // Cycle stays asserted across stream stalls until the last beat is acked.
            r_cyc <= (r_state == S_ACTIVE) && (w_state_next == S_ACTIVE) &&
                     (r_cyc || w_stb);

            if (w_load) begin
                r_addr       <= cfg_adr_i;
                r_words_left <= cfg_len_i;
                r_words_in   <= cfg_len_i;
                r_beat       <= '0;
                r_burst      <= f_burst(cfg_len_i);
                r_hold_valid <= 1'b0;
            end else if (w_err) begin
                r_hold_valid <= 1'b0;
                r_words_left <= '0;
                r_words_in   <= '0;
                r_beat       <= '0;
            end else begin
                if (w_ack) begin
                    r_addr       <= r_addr + c_STEP;
                    r_words_left <= r_words_left - AW'(1);
                    r_beat       <= r_beat + c_BEAT_W'(1);
                end
                if (w_rearm) begin
                    r_beat  <= '0;
                    r_burst <= f_burst(r_words_left);
                end
                if (w_accept) begin
                    r_hold_valid <= 1'b1;
                    r_hold_data  <= bus.stream_s_data_i;
                    r_words_in   <= r_words_in - AW'(1);
                end else if (w_ack) begin
                    r_hold_valid <= 1'b0;
                end
            end
        end
    end

    assign busy_o               = (r_state != S_IDLE);
    assign done_o               = r_done;
    assign err_o                = r_err;

    assign bus.stream_s_ready_o = w_ready;
    assign bus.wbm_adr_o        = r_addr;
    assign bus.wbm_dat_o        = r_hold_data;
    assign bus.wbm_sel_o        = '1;
    assign bus.wbm_we_o         = 1'b1;
    assign bus.wbm_stb_o        = w_stb;
    assign bus.wbm_cyc_o        = (r_state == S_ACTIVE) && (r_cyc || r_hold_valid);
    assign bus.wbm_cti_o        = w_stb ? (w_last ? 3'b111 : 3'b010) : 3'b000;
    assign bus.wbm_bte_o        = 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_stream_wb_burst_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_stream_wb_burst_writer : randomized scoreboard bench for the burst writer
// Revision 1.0
// ============================================================================
module tb_stream_wb_burst_writer;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BL = 16;
    localparam logic [DW/8-1:0] SEL_ALL = '1;

    typedef struct packed {
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [2:0]    cti;
    } beat_t;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          cfg_start = 1'b0;
    logic [AW-1:0] cfg_adr   = '0;
    logic [AW-1:0] cfg_len   = '0;
    logic          busy;
    logic          done;
    logic          err;

    stream_wb_burst_writer_if #(.AW(AW), .DW(DW)) bus ();

    stream_wb_burst_writer #(.AW(AW), .DW(DW), .BURST_LEN(BL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_start_i (cfg_start),
        .cfg_adr_i   (cfg_adr),
        .cfg_len_i   (cfg_len),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    beat_t         exp_q[$];
    logic [DW-1:0] stream_q[$];

    int gap_pct    = 0;
    int stall_pct  = 0;
    int acks_total = 0;
    int done_cnt   = 0;
    int acc_cnt    = 0;
    int last_cnt   = 0;
    int err_target = -1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Stream source: holds valid until the word is taken.
    initial begin : stream_drv
        bit fire;
        bus.stream_s_valid_i = 1'b0;
        bus.stream_s_data_i  = '0;
        forever begin
            @(negedge clk);
            fire = rst_n && bus.stream_s_valid_i && bus.stream_s_ready_o;
            @(posedge clk);
            #1;
            if (fire && stream_q.size() > 0) void'(stream_q.pop_front());
            if (stream_q.size() == 0) begin
                bus.stream_s_valid_i = 1'b0;
            end else begin
                if (!bus.stream_s_valid_i || fire)
                    bus.stream_s_valid_i = ($urandom_range(99) >= gap_pct);
                bus.stream_s_data_i = stream_q[0];
            end
        end
    end

    // Wishbone slave: random ack stalls, error injected on a chosen beat.
    initial begin : slave_drv
        bus.wbm_ack_i = 1'b0;
        bus.wbm_err_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.wbm_stb_o) begin
                if (err_target >= 0 && acks_total == err_target) begin
                    bus.wbm_err_i = 1'b1;
                    bus.wbm_ack_i = 1'b1;
                end else begin
                    bus.wbm_err_i = 1'b0;
                    bus.wbm_ack_i = ($urandom_range(99) >= stall_pct);
                end
            end else begin
                bus.wbm_ack_i = 1'b0;
                bus.wbm_err_i = 1'b0;
            end
        end
    end

    initial begin : monitor
        beat_t         e;
        bit            p_stall = 1'b0;
        bit            p_last  = 1'b0;
        bit            p_hold  = 1'b0;
        bit            p_err   = 1'b0;
        logic [AW-1:0] p_adr   = '0;
        logic [DW-1:0] p_dat   = '0;
        bit            stb, ack, erri;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_stall = 1'b0; p_last = 1'b0; p_hold = 1'b0; p_err = 1'b0;
            end else begin
                stb  = bus.wbm_stb_o;
                ack  = bus.wbm_ack_i;
                erri = bus.wbm_err_i;
                if (bus.stream_s_valid_i && bus.stream_s_ready_o) acc_cnt++;
                if (done) done_cnt++;
                if (p_stall) begin
                    check("stall_stb", bus.wbm_stb_o, 1'b1);
                    check("stall_adr", bus.wbm_adr_o, p_adr);
                    check("stall_dat", bus.wbm_dat_o, p_dat);
                end
                if (p_err) begin
                    check("err_cyc_drop", bus.wbm_cyc_o, 1'b0);
                    check("err_stb_drop", bus.wbm_stb_o, 1'b0);
                    check("err_flag", err, 1'b1);
                    check("err_done", done, 1'b1);
                end else if (p_last) begin
                    check("gap_cyc", bus.wbm_cyc_o, 1'b0);
                end else if (p_hold) begin
                    check("cyc_hold", bus.wbm_cyc_o, 1'b1);
                end
                if (stb) check("stb_needs_cyc", bus.wbm_cyc_o, 1'b1);
                if (stb && ack && !erri) begin
                    acks_total++;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_write: got adr 0x%0h dat 0x%0h, expected no write",
                                 bus.wbm_adr_o, bus.wbm_dat_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_adr", bus.wbm_adr_o, e.adr);
                        check("wr_dat", bus.wbm_dat_o, e.dat);
                        check("wr_cti", bus.wbm_cti_o, e.cti);
                        check("wr_sel", bus.wbm_sel_o, SEL_ALL);
                        check("wr_we",  bus.wbm_we_o, 1'b1);
                        check("wr_bte", bus.wbm_bte_o, 2'b00);
                    end
                    if (bus.wbm_cti_o == 3'b111) last_cnt++;
                end
                p_err   = stb && erri;
                p_last  = stb && ack && !erri && (bus.wbm_cti_o == 3'b111);
                p_stall = stb && !ack && !erri;
                p_hold  = bus.wbm_cyc_o && !p_err && !p_last;
                p_adr   = bus.wbm_adr_o;
                p_dat   = bus.wbm_dat_o;
            end
        end
    end

    // Reference model: beat i goes to adr + i*DW/8; bursts are BL-beat groups from the start.
    task automatic load_xfer(input logic [AW-1:0] adr, input int len, input int n_exp,
                             input bit use_seq, input logic [DW-1:0] seq);
        beat_t         b;
        logic [DW-1:0] d;
        for (int i = 0; i < len; i++) begin
            d = use_seq ? (seq + DW'(i)) : DW'($urandom);
            stream_q.push_back(d);
            if (i < n_exp) begin
                b.adr = adr + AW'(i * (DW / 8));
                b.dat = d;
                b.cti = (((i % BL) == BL - 1) || (i == len - 1)) ? 3'b111 : 3'b010;
                exp_q.push_back(b);
            end
        end
        @(posedge clk);
        #1;
        cfg_adr   = adr;
        cfg_len   = AW'(len);
        cfg_start = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
    endtask

    task automatic run_xfer(input logic [AW-1:0] adr, input int len, input int n_exp,
                            input int exp_words, input bit use_seq, input logic [DW-1:0] seq,
                            input int poke_at, input string nm);
        int bd, ba, bl, bk, c, exp_last;
        bit poked;
        bd = done_cnt; ba = acc_cnt; bl = last_cnt; bk = acks_total;
        poked = 1'b0;
        exp_last = 0;
        for (int i = 0; i < n_exp; i++)
            if (((i % BL) == BL - 1) || (i == len - 1)) exp_last++;
        load_xfer(adr, len, n_exp, use_seq, seq);
        c = 0;
        while (done_cnt == bd && c < len * 40 + 200) begin
            @(posedge clk);
            c++;
            if (poke_at >= 0 && !poked && (acks_total - bk) >= poke_at) begin
                #1;
                check({nm, "_poke_busy"}, busy, 1'b1);
                cfg_adr   = 32'h0000_8000;
                cfg_len   = 32'd3;
                cfg_start = 1'b1;
                @(posedge clk);
                #1;
                cfg_start = 1'b0;
                poked = 1'b1;
                c++;
            end
        end
        check({nm, "_done_seen"}, done_cnt - bd, 1);
        repeat (2) @(posedge clk);
        #1;
        check({nm, "_done_once"}, done_cnt - bd, 1);
        check({nm, "_idle"}, busy, 1'b0);
        check({nm, "_bursts"}, last_cnt - bl, exp_last);
        check({nm, "_sb_empty"}, exp_q.size(), 0);
        if (exp_words >= 0) check({nm, "_words_taken"}, acc_cnt - ba, exp_words);
        stream_q.delete();
        exp_q.delete();
    endtask

    initial begin : main
        int bd, bk, c, total, len;
        logic [AW-1:0] adr;

        @(posedge clk);
        #2;
        check("rst_busy",  busy, 1'b0);
        check("rst_done",  done, 1'b0);
        check("rst_err",   err, 1'b0);
        check("rst_cyc",   bus.wbm_cyc_o, 1'b0);
        check("rst_stb",   bus.wbm_stb_o, 1'b0);
        check("rst_ready", bus.stream_s_ready_o, 1'b0);
        check("rst_we",    bus.wbm_we_o, 1'b1);
        check("rst_sel",   bus.wbm_sel_o, SEL_ALL);
        check("rst_bte",   bus.wbm_bte_o, 2'b00);
        check("rst_adr",   bus.wbm_adr_o, '0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        run_xfer(32'h0000_1000, 4, 4, 4, 1'b1, 32'hA0, -1, "basic");
        run_xfer(32'h0000_1000, 40, 40, 40, 1'b0, '0, -1, "multi");

        err_target = acks_total + 3;
        run_xfer(32'h0000_3000, 8, 3, -1, 1'b0, '0, -1, "error");
        check("error_sticky", err, 1'b1);
        err_target = -1;
        run_xfer(32'h0000_4000, 2, 2, 2, 1'b0, '0, -1, "after_err");
        check("err_cleared", err, 1'b0);

        bd = done_cnt;
        @(posedge clk);
        #1;
        cfg_adr = 32'h0000_7000; cfg_len = '0; cfg_start = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        check("zero_done_pulse", done, 1'b1);
        check("zero_no_cyc", bus.wbm_cyc_o, 1'b0);
        check("zero_not_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        check("zero_done_low", done, 1'b0);
        repeat (2) @(posedge clk);
        check("zero_done_once", done_cnt - bd, 1);

        run_xfer(32'h0000_2000, 20, 20, 20, 1'b0, '0, 5, "busy_start");

        // Async reset part-way through a 16-beat burst.
        bd = done_cnt; bk = acks_total;
        load_xfer(32'h0000_5000, 16, 16, 1'b0, '0);
        c = 0;
        while ((acks_total - bk) < 4 && c < 500) begin
            @(posedge clk);
            c++;
        end
        check("rst_mid_reached", (acks_total - bk) >= 4, 1'b1);
        #2;
        check("rst_mid_pre_cyc", bus.wbm_cyc_o, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_cyc",   bus.wbm_cyc_o, 1'b0);
        check("rst_mid_stb",   bus.wbm_stb_o, 1'b0);
        check("rst_mid_busy",  busy, 1'b0);
        check("rst_mid_ready", bus.stream_s_ready_o, 1'b0);
        exp_q.delete();
        stream_q.delete();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_mid_no_done", done_cnt - bd, 0);
        run_xfer(32'h0000_6000, 5, 5, 5, 1'b0, '0, -1, "after_rst");

        total = 0;
        while (total < 1000) begin
            gap_pct   = $urandom_range(60);
            stall_pct = $urandom_range(60);
            len       = $urandom_range(120, 1);
            adr       = AW'($urandom) & ~AW'(DW / 8 - 1);
            run_xfer(adr, len, len, len, 1'b0, '0, -1, "rand");
            total += len;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
